// File: rtl/obi_data_mem.sv
// obi_data_mem: OBI data memory slave with byte-enable stores, a fixed-latency
// in-order response pipeline, an outstanding-transaction limit and an error
// response for addresses outside the mapped window.
module obi_data_mem #(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned RVALID_LATENCY  = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  input  logic        stall_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // 33 bits so a window ending exactly at 4 GiB does not wrap to zero.
  localparam logic [32:0] LIMIT   = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [2:0]  MAX_OUT = 3'(MAX_OUTSTANDING);
  localparam int unsigned L       = RVALID_LATENCY;

  logic [2:0]       r_outstanding;
  logic             w_gnt;
  logic             w_hit;
  logic             w_wr;
  logic             w_rd;
  logic [31:0]      w_offset;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rd_word;

  // Grant is withheld while the counter is full, even if a response retires
  // this very cycle: no bypass from rvalid into the grant path.
  assign w_gnt      = data_req_i & ~stall_i & (r_outstanding < MAX_OUT);
  assign data_gnt_o = w_gnt;

  assign w_hit    = (data_addr_i >= BASE_ADDR) && ({1'b0, data_addr_i} < LIMIT);
  assign w_offset = data_addr_i - BASE_ADDR;
  assign w_idx    = IDX_W'(w_offset >> 2);
  assign w_wr     = w_gnt & w_hit & data_we_i;
  assign w_rd     = w_gnt & w_hit & ~data_we_i;

  // One RAM per byte lane so each lane's write enable is independent and the
  // read port stays a plain registered read.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH_WORDS];
      logic [7:0] r_rd;

      // Lane write on a granted store; sample the word on a granted load.
      always_ff @(posedge clk) begin
        if (w_wr && data_be_i[gi]) begin
          r_mem[w_idx] <= data_wdata_i[8*gi +: 8];
        end
        if (w_rd) begin
          r_rd <= r_mem[w_idx];
        end
      end

      assign w_rd_word[8*gi +: 8] = r_rd;
    end
  endgenerate

  // Head of the response pipeline; the RAM read register sits alongside it,
  // masked to zero unless the response belongs to a successful load.
  logic r_head_vld;
  logic r_head_err;
  logic r_head_load;

  // Capture response attributes of the transaction granted this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_vld  <= 1'b0;
      r_head_err  <= 1'b0;
      r_head_load <= 1'b0;
    end else begin
      r_head_vld  <= w_gnt;
      r_head_err  <= w_gnt & ~w_hit;
      r_head_load <= w_rd;
    end
  end

  logic        w_stg_vld   [L];
  logic        w_stg_err   [L];
  logic [31:0] w_stg_rdata [L];

  assign w_stg_vld[0]   = r_head_vld;
  assign w_stg_err[0]   = r_head_err;
  assign w_stg_rdata[0] = r_head_load ? w_rd_word : 32'h0;

  generate
    for (gi = 1; gi < L; gi++) begin : g_stage
      logic        r_vld;
      logic        r_err;
      logic [31:0] r_rdata;

      // Delay stage; idle slots carry zeros so outputs are clean when invalid.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld   <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= 32'h0;
        end else begin
          r_vld   <= w_stg_vld[gi-1];
          r_err   <= w_stg_err[gi-1];
          r_rdata <= w_stg_rdata[gi-1];
        end
      end

      assign w_stg_vld[gi]   = r_vld;
      assign w_stg_err[gi]   = r_err;
      assign w_stg_rdata[gi] = r_rdata;
    end
  endgenerate

  assign data_rvalid_o = w_stg_vld[L-1];
  assign data_err_o    = w_stg_err[L-1];
  assign data_rdata_o  = w_stg_rdata[L-1];

  // Track granted-but-unanswered transactions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= 3'd0;
    end else if (w_gnt && !data_rvalid_o) begin
      r_outstanding <= r_outstanding + 3'd1;
    end else if (!w_gnt && data_rvalid_o) begin
      r_outstanding <= r_outstanding - 3'd1;
    end
  end

endmodule
